vbmap_ctl_1rnwg_mt: RTL and testbench

- Parametrised virtual-to-physical bank-map controller for 1-read / N-write group memories.
- Each incoming read or write carries a (vbank, row) address; the block issues it as a (pbank, row) access.
- Write/read and write/write physical-bank conflicts are resolved by remapping the write to a free spare bank of that row, with the updated map row written back.
- Sits between the virtual-port front end and the physical bank mux. Generalises the fixed 2-write map core to NUMWRPT ports, adds a self-initialising map table and in-flight map-row bypass.

---
 rtl/vbmap_ctl_1rnwg_mt_if.sv | 41 ++++
 rtl/vbmap_ctl_1rnwg_mt.sv | 231 +++++++++++++++++++++++
 tb/tb_vbmap_ctl_1rnwg_mt.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/vbmap_ctl_1rnwg_mt_if.sv
// Request, physical-access and map-table signals of the 1R/NW bank-map controller.
// Requests are single-cycle valid strobes accepted whenever ready is high; there is no backpressure.
interface vbmap_ctl_1rnwg_mt_if #(
    parameter int NUMWRPT = 2,
    parameter int BITVBNK = 3,
    parameter int BITPBNK = 4,
    parameter int BITVROW = 10,
    parameter int BITMAPT = 44
);
    logic                             ready;
    logic                             vread;
    logic [BITVBNK-1:0]               vrdvbnk;
    logic [BITVROW-1:0]               vrdradr;
    logic [NUMWRPT-1:0]               vwrite;
    logic [NUMWRPT*BITVBNK-1:0]       vwrvbnk;
    logic [NUMWRPT*BITVROW-1:0]       vwrradr;
    logic                             pread;
    logic [BITPBNK-1:0]               prdbadr;
    logic [BITVROW-1:0]               prdradr;
    logic [NUMWRPT-1:0]               pwrite;
    logic [NUMWRPT*BITPBNK-1:0]       pwrbadr;
    logic [NUMWRPT*BITVROW-1:0]       pwrradr;
    logic [NUMWRPT:0]                 m_read;
    logic [(NUMWRPT+1)*BITVROW-1:0]   m_rdradr;
    logic [(NUMWRPT+1)*BITMAPT-1:0]   m_dout;
    logic [NUMWRPT-1:0]               m_write;
    logic [NUMWRPT*BITVROW-1:0]       m_wrradr;
    logic [NUMWRPT*BITMAPT-1:0]       m_din;

    modport master (
        input  ready, pread, prdbadr, prdradr, pwrite, pwrbadr, pwrradr,
               m_read, m_rdradr, m_write, m_wrradr, m_din,
        output vread, vrdvbnk, vrdradr, vwrite, vwrvbnk, vwrradr, m_dout
    );

    modport slave (
        output ready, pread, prdbadr, prdradr, pwrite, pwrbadr, pwrradr,
               m_read, m_rdradr, m_write, m_wrradr, m_din,
        input  vread, vrdvbnk, vrdradr, vwrite, vwrvbnk, vwrradr, m_dout
    );
endinterface

// File: rtl/vbmap_ctl_1rnwg_mt.sv
// Virtual-to-physical bank map for a 1-read / N-write memory: writes that collide on a
// physical bank are moved to a spare bank of their row and the updated map row is written back.
module vbmap_ctl_1rnwg_mt #(
    parameter int NUMWRPT    = 2,
    parameter int NUMVBNK    = 8,
    parameter int BITVBNK    = 3,
    parameter int NUMPBNK    = 11,
    parameter int BITPBNK    = 4,
    parameter int NUMVROW    = 1024,
    parameter int BITVROW    = 10,
    parameter int SRAM_DELAY = 1,
    parameter int BITMAPT    = BITPBNK * NUMPBNK
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       dbg_state_o,
    vbmap_ctl_1rnwg_mt_if.slave        bus
);
    localparam int NP   = NUMWRPT + 1;
    localparam int LAST = SRAM_DELAY - 1;

    typedef logic [NUMPBNK-1:0][BITPBNK-1:0]              maprow_t;
    typedef logic [NUMWRPT-1:0][NUMPBNK-1:0][BITPBNK-1:0] wrrows_t;
    typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

    function automatic maprow_t ident_row();
        maprow_t r;
        for (int i = 0; i < NUMPBNK; i++) r[i] = BITPBNK'(i);
        return r;
    endfunction

    function automatic logic [BITPBNK-1:0] pidx(input logic [BITVBNK-1:0] vb);
        return BITPBNK'(vb);
    endfunction

    localparam maprow_t IDENT = ident_row();

    state_t                              state_q;
    logic [BITVROW-1:0]                  row_q;
    logic                                ready_q;

    // Request pipeline covering the map-table read latency; index LAST is the resolve stage.
    logic [SRAM_DELAY-1:0]               rd_v_q;
    logic [BITVBNK-1:0]                  rd_vb_q  [SRAM_DELAY];
    logic [BITVROW-1:0]                  rd_row_q [SRAM_DELAY];
    logic [NUMWRPT-1:0]                  wr_v_q   [SRAM_DELAY];
    logic [NUMWRPT-1:0][BITVBNK-1:0]     wr_vb_q  [SRAM_DELAY];
    logic [NUMWRPT-1:0][BITVROW-1:0]     wr_row_q [SRAM_DELAY];

    logic [NUMWRPT-1:0]                  hist_wr_q   [SRAM_DELAY];
    logic [NUMWRPT-1:0][BITVROW-1:0]     hist_radr_q [SRAM_DELAY];
    wrrows_t                             hist_din_q  [SRAM_DELAY];

    logic                                pread_q;
    logic [BITPBNK-1:0]                  prdbadr_q;
    logic [BITVROW-1:0]                  prdradr_q;
    logic [NUMWRPT-1:0]                  pwrite_q;
    logic [NUMWRPT-1:0][BITPBNK-1:0]     pwrbadr_q;
    logic [NUMWRPT-1:0][BITVROW-1:0]     pwrradr_q;
    logic [NUMWRPT-1:0]                  m_write_q;
    logic [NUMWRPT-1:0][BITVROW-1:0]     m_wrradr_q;
    wrrows_t                             m_din_q;

    logic [NP-1:0][NUMPBNK-1:0][BITPBNK-1:0] dout;
    logic [NUMWRPT-1:0][BITVBNK-1:0]     vwrvbnk_w;
    logic [NUMWRPT-1:0][BITVROW-1:0]     vwrradr_w;
    logic [BITVROW-1:0]                  port_row [NP];
    maprow_t                             byp_row  [NP];

    logic [BITPBNK-1:0]                  rd_pb;
    logic [NUMWRPT-1:0]                  kill, act, chg, mw;
    wrrows_t                             work;
    logic [NUMWRPT-1:0][BITPBNK-1:0]     wpb;

    assign dout      = bus.m_dout;
    assign vwrvbnk_w = bus.vwrvbnk;
    assign vwrradr_w = bus.vwrradr;

    assign bus.ready    = ready_q;
    assign bus.m_read   = ready_q ? {bus.vwrite, bus.vread} : '0;
    assign bus.m_rdradr = ready_q ? {bus.vwrradr, bus.vrdradr} : '0;
    assign bus.pread    = pread_q;
    assign bus.prdbadr  = prdbadr_q;
    assign bus.prdradr  = prdradr_q;
    assign bus.pwrite   = pwrite_q;
    assign bus.pwrbadr  = pwrbadr_q;
    assign bus.pwrradr  = pwrradr_q;
    assign bus.m_write  = m_write_q;
    assign bus.m_wrradr = m_wrradr_q;
    assign bus.m_din    = m_din_q;
    assign dbg_state_o  = state_q;

    // Returned map rows may be stale; the newest in-flight write-back of the same row wins.
    always_comb begin
        port_row[0] = rd_row_q[LAST];
        for (int k = 0; k < NUMWRPT; k++) port_row[k+1] = wr_row_q[LAST][k];
        for (int p = 0; p < NP; p++) begin
            byp_row[p] = dout[p];
            for (int i = SRAM_DELAY - 1; i >= 0; i--)
                for (int k = 0; k < NUMWRPT; k++)
                    if (hist_wr_q[i][k] && hist_radr_q[i][k] == port_row[p]) byp_row[p] = hist_din_q[i][k];
            for (int k = 0; k < NUMWRPT; k++)
                if (m_write_q[k] && m_wrradr_q[k] == port_row[p]) byp_row[p] = m_din_q[k];
        end
    end

    always_comb begin
        logic [BITPBNK-1:0] cur, fsel, fidx, fbank;
        logic               conflict, busy, found;
        cur = '0; fsel = '0; fidx = '0; fbank = '0;
        conflict = 1'b0; busy = 1'b0; found = 1'b0;
        kill = '0; chg = '0; mw = '0; work = '0; wpb = '0;
        rd_pb = byp_row[0][pidx(rd_vb_q[LAST])];
        for (int k = 0; k < NUMWRPT; k++)
            for (int j = k + 1; j < NUMWRPT; j++)
                if (wr_v_q[LAST][j] && wr_v_q[LAST][k] && wr_row_q[LAST][j] == wr_row_q[LAST][k] &&
                    wr_vb_q[LAST][j] == wr_vb_q[LAST][k]) kill[k] = 1'b1;
        act = wr_v_q[LAST] & ~kill;
        for (int k = 0; k < NUMWRPT; k++) begin
            work[k] = byp_row[k+1];
            for (int j = 0; j < k; j++)
                if (act[j] && wr_row_q[LAST][j] == wr_row_q[LAST][k]) begin
                    work[k] = work[j];
                    chg[k]  = chg[j];
                end
            cur      = work[k][pidx(wr_vb_q[LAST][k])];
            conflict = rd_v_q[LAST] && (cur == rd_pb);
            for (int j = 0; j < k; j++)
                if (act[j] && wpb[j] == cur) conflict = 1'b1;
            wpb[k] = cur;
            if (act[k] && conflict) begin
                found = 1'b0; fsel = '0; fidx = '0;
                for (int f = NUMVBNK; f < NUMPBNK; f++) begin
                    fbank = work[k][BITPBNK'(f)];
                    busy  = rd_v_q[LAST] && (fbank == rd_pb);
                    for (int j = 0; j < k; j++)
                        if (act[j] && wpb[j] == fbank) busy = 1'b1;
                    if (!found && !busy) begin
                        found = 1'b1;
                        fsel  = fbank;
                        fidx  = BITPBNK'(f);
                    end
                end
                work[k][pidx(wr_vb_q[LAST][k])] = fsel;
                work[k][fidx] = cur;
                wpb[k] = fsel;
                chg[k] = 1'b1;
            end
        end
        // Only the last port of a same-row group writes the merged row back.
        for (int k = 0; k < NUMWRPT; k++) begin
            mw[k] = act[k] & chg[k];
            for (int j = k + 1; j < NUMWRPT; j++)
                if (act[j] && wr_row_q[LAST][j] == wr_row_q[LAST][k]) mw[k] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_INIT;
            row_q      <= '0;
            ready_q    <= 1'b0;
            rd_v_q     <= '0;
            for (int i = 0; i < SRAM_DELAY; i++) begin
                rd_vb_q[i]     <= '0;
                rd_row_q[i]    <= '0;
                wr_v_q[i]      <= '0;
                wr_vb_q[i]     <= '0;
                wr_row_q[i]    <= '0;
                hist_wr_q[i]   <= '0;
                hist_radr_q[i] <= '0;
                hist_din_q[i]  <= '0;
            end
            pread_q    <= 1'b0;
            prdbadr_q  <= '0;
            prdradr_q  <= '0;
            pwrite_q   <= '0;
            pwrbadr_q  <= '0;
            pwrradr_q  <= '0;
            m_write_q  <= '0;
            m_wrradr_q <= '0;
            m_din_q    <= '0;
        end else begin
            rd_v_q[0]   <= ready_q & bus.vread;
            rd_vb_q[0]  <= bus.vrdvbnk;
            rd_row_q[0] <= bus.vrdradr;
            wr_v_q[0]   <= ready_q ? bus.vwrite : '0;
            wr_vb_q[0]  <= vwrvbnk_w;
            wr_row_q[0] <= vwrradr_w;
            for (int i = 1; i < SRAM_DELAY; i++) begin
                rd_v_q[i]   <= rd_v_q[i-1];
                rd_vb_q[i]  <= rd_vb_q[i-1];
                rd_row_q[i] <= rd_row_q[i-1];
                wr_v_q[i]   <= wr_v_q[i-1];
                wr_vb_q[i]  <= wr_vb_q[i-1];
                wr_row_q[i] <= wr_row_q[i-1];
                hist_wr_q[i]   <= hist_wr_q[i-1];
                hist_radr_q[i] <= hist_radr_q[i-1];
                hist_din_q[i]  <= hist_din_q[i-1];
            end
            hist_wr_q[0]   <= m_write_q;
            hist_radr_q[0] <= m_wrradr_q;
            hist_din_q[0]  <= m_din_q;
            ready_q <= (state_q == S_RUN);
            case (state_q)
                S_INIT: begin
                    pread_q       <= 1'b0;
                    pwrite_q      <= '0;
                    m_write_q     <= NUMWRPT'(1);
                    m_wrradr_q    <= '0;
                    m_wrradr_q[0] <= row_q;
                    m_din_q       <= '0;
                    m_din_q[0]    <= IDENT;
                    row_q         <= row_q + 1'b1;
                    if (row_q == BITVROW'(NUMVROW - 1)) state_q <= S_RUN;
                end
                default: begin
                    pread_q    <= rd_v_q[LAST];
                    prdbadr_q  <= rd_pb;
                    prdradr_q  <= rd_row_q[LAST];
                    pwrite_q   <= act;
                    pwrbadr_q  <= wpb;
                    pwrradr_q  <= wr_row_q[LAST];
                    m_write_q  <= mw;
                    m_wrradr_q <= wr_row_q[LAST];
                    m_din_q    <= work;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vbmap_ctl_1rnwg_mt.sv
// Directed bench for the bank-map controller with a behavioural map-table SRAM.
module tb_vbmap_ctl_1rnwg_mt;
  localparam int NUMWRPT = 2, NUMVBNK = 8, BITVBNK = 3, NUMPBNK = 11, BITPBNK = 4;
  localparam int NUMVROW = 1024, BITVROW = 10, SRAM_DELAY = 1, BITMAPT = BITPBNK * NUMPBNK;
  localparam int NV = 9;

  typedef logic [NUMPBNK-1:0][BITPBNK-1:0] maprow_t;
  typedef struct {
    logic vread; logic [2:0] rvb; logic [9:0] rrow;
    logic [1:0] vw; logic [2:0] wvb0; logic [9:0] wrow0; logic [2:0] wvb1; logic [9:0] wrow1;
    logic [1:0] e_pw; logic [3:0] e_prd; logic [3:0] e_pw0; logic [3:0] e_pw1;
    logic [1:0] e_mw; logic [3:0] e_ent; logic [3:0] e_entv; logic [3:0] e_fr; logic [3:0] e_frv;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dbg_state;
  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs [NV];
  maprow_t ident;
  logic [BITMAPT-1:0] mem [NUMVROW];

  vbmap_ctl_1rnwg_mt_if #(.NUMWRPT(NUMWRPT), .BITVBNK(BITVBNK), .BITPBNK(BITPBNK),
                          .BITVROW(BITVROW), .BITMAPT(BITMAPT)) bus_if ();

  vbmap_ctl_1rnwg_mt #(.NUMWRPT(NUMWRPT), .NUMVBNK(NUMVBNK), .BITVBNK(BITVBNK), .NUMPBNK(NUMPBNK),
                       .BITPBNK(BITPBNK), .NUMVROW(NUMVROW), .BITVROW(BITVROW),
                       .SRAM_DELAY(SRAM_DELAY), .BITMAPT(BITMAPT)) dut (
    .clk(clk), .rst(rst), .dbg_state_o(dbg_state), .bus(bus_if));

  // clock / reset
  always #5 clk = ~clk;

  // map-table SRAM: one-cycle read, read-before-write
  always @(posedge clk) begin
    for (int p = 0; p <= NUMWRPT; p++)
      if (bus_if.m_read[p])
        bus_if.m_dout[p*BITMAPT +: BITMAPT] <= mem[bus_if.m_rdradr[p*BITVROW +: BITVROW]];
    for (int k = 0; k < NUMWRPT; k++)
      if (bus_if.m_write[k]) mem[bus_if.m_wrradr[k*BITVROW +: BITVROW]] <= bus_if.m_din[k*BITMAPT +: BITMAPT];
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    bus_if.vread = 1'b0; bus_if.vrdvbnk = '0; bus_if.vrdradr = '0;
    bus_if.vwrite = '0; bus_if.vwrvbnk = '0; bus_if.vwrradr = '0;
  endtask

  task automatic drive(input vec_t v);
    bus_if.vread = v.vread; bus_if.vrdvbnk = v.rvb; bus_if.vrdradr = v.rrow;
    bus_if.vwrite = v.vw; bus_if.vwrvbnk = {v.wvb1, v.wvb0}; bus_if.vwrradr = {v.wrow1, v.wrow0};
  endtask

  function automatic vec_t mk(logic vr, logic [2:0] rvb, logic [9:0] rrow, logic [1:0] vw,
                              logic [2:0] wvb0, logic [9:0] wrow0, logic [2:0] wvb1, logic [9:0] wrow1,
                              logic [1:0] epw, logic [3:0] eprd, logic [3:0] epw0, logic [3:0] epw1,
                              logic [1:0] emw, logic [3:0] eent, logic [3:0] eentv,
                              logic [3:0] efr, logic [3:0] efrv);
    vec_t v;
    v.vread = vr; v.rvb = rvb; v.rrow = rrow; v.vw = vw;
    v.wvb0 = wvb0; v.wrow0 = wrow0; v.wvb1 = wvb1; v.wrow1 = wrow1;
    v.e_pw = epw; v.e_prd = eprd; v.e_pw0 = epw0; v.e_pw1 = epw1;
    v.e_mw = emw; v.e_ent = eent; v.e_entv = eentv; v.e_fr = efr; v.e_frv = efrv;
    return v;
  endfunction

  initial begin
    maprow_t r;
    int kp;
    logic [9:0] wrow;
    for (int i = 0; i < NUMPBNK; i++) ident[i] = BITPBNK'(i);
    // vectors applied one at a time on a freshly initialised map; later ones see earlier write-backs
    vecs[0] = mk(1, 3, 5,  2'b01, 3, 5,  0, 0,  2'b01, 3, 8, 0,  2'b01, 3, 8, 8, 3);
    vecs[1] = mk(1, 1, 7,  2'b11, 1, 7,  2, 7,  2'b11, 1, 8, 2,  2'b10, 1, 8, 8, 1);
    vecs[2] = mk(0, 0, 0,  2'b11, 4, 2,  4, 2,  2'b10, 0, 0, 4,  2'b00, 0, 0, 0, 0);
    vecs[3] = mk(1, 3, 5,  2'b00, 0, 0,  0, 0,  2'b00, 8, 0, 0,  2'b00, 0, 0, 0, 0);
    vecs[4] = mk(0, 0, 0,  2'b01, 3, 5,  0, 0,  2'b01, 0, 8, 0,  2'b00, 0, 0, 0, 0);
    vecs[5] = mk(1, 0, 20, 2'b11, 5, 30, 0, 30, 2'b11, 0, 5, 8,  2'b10, 0, 8, 8, 0);
    vecs[6] = mk(1, 2, 40, 2'b11, 2, 41, 2, 42, 2'b11, 2, 8, 9,  2'b11, 2, 9, 9, 2);
    vecs[7] = mk(0, 0, 0,  2'b11, 6, 50, 6, 51, 2'b11, 0, 6, 8,  2'b10, 6, 8, 8, 6);
    vecs[8] = mk(1, 1, 7,  2'b01, 1, 7,  0, 0,  2'b01, 8, 1, 0,  2'b01, 1, 1, 8, 8);

    // reset state, with requests presented that must be ignored
    bus_if.vread = 1'b1; bus_if.vrdvbnk = 3'd2; bus_if.vrdradr = 10'd3;
    bus_if.vwrite = 2'b11; bus_if.vwrvbnk = 6'o12; bus_if.vwrradr = {10'd4, 10'd5};
    repeat (2) @(posedge clk);
    #2;
    chk("rst_outputs", {bus_if.ready, bus_if.pread, bus_if.pwrite, bus_if.m_write, bus_if.m_read}, 0);
    chk("rst_wrradr", bus_if.m_wrradr, 0);
    chk("rst_state", dbg_state, 0);
    @(negedge clk) rst = 1'b1;

    for (int c = 0; c < NUMVROW; c++) begin
      @(posedge clk); #1;
      chk("init_mwrite", bus_if.m_write, 2'b01);
      chk("init_row", bus_if.m_wrradr[BITVROW-1:0], c);
      chk("init_din", bus_if.m_din[BITMAPT-1:0], ident);
      chk("init_quiet", {bus_if.ready, bus_if.pread, bus_if.pwrite, bus_if.m_read}, 0);
    end
    idle();
    @(posedge clk); #1;
    chk("ready_rise", bus_if.ready, 1);
    chk("run_no_mwrite", bus_if.m_write, 0);
    chk("run_state", dbg_state, 1);

    // table-driven vectors
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      @(posedge clk); #1;
      idle();
      chk($sformatf("v%0d_early", i), {bus_if.pread, bus_if.pwrite, bus_if.m_write}, 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_pread", i), bus_if.pread, vecs[i].vread);
      if (vecs[i].vread) begin
        chk($sformatf("v%0d_prdbadr", i), bus_if.prdbadr, vecs[i].e_prd);
        chk($sformatf("v%0d_prdradr", i), bus_if.prdradr, vecs[i].rrow);
      end
      chk($sformatf("v%0d_pwrite", i), bus_if.pwrite, vecs[i].e_pw);
      if (vecs[i].e_pw[0]) begin
        chk($sformatf("v%0d_pwrbadr0", i), bus_if.pwrbadr[3:0], vecs[i].e_pw0);
        chk($sformatf("v%0d_pwrradr0", i), bus_if.pwrradr[9:0], vecs[i].wrow0);
      end
      if (vecs[i].e_pw[1]) begin
        chk($sformatf("v%0d_pwrbadr1", i), bus_if.pwrbadr[7:4], vecs[i].e_pw1);
        chk($sformatf("v%0d_pwrradr1", i), bus_if.pwrradr[19:10], vecs[i].wrow1);
      end
      chk($sformatf("v%0d_mwrite", i), bus_if.m_write, vecs[i].e_mw);
      if (vecs[i].e_mw != 2'b00) begin
        kp = vecs[i].e_mw[1] ? 1 : 0;
        wrow = (kp == 1) ? vecs[i].wrow1 : vecs[i].wrow0;
        r = bus_if.m_din[kp*BITMAPT +: BITMAPT];
        chk($sformatf("v%0d_mwrradr", i), bus_if.m_wrradr[kp*BITVROW +: BITVROW], wrow);
        chk($sformatf("v%0d_din_vbank", i), r[vecs[i].e_ent], vecs[i].e_entv);
        chk($sformatf("v%0d_din_free", i), r[vecs[i].e_fr], vecs[i].e_frv);
      end
      repeat (3) @(posedge clk);
      #1;
    end

    // back-to-back: second read must see the remap of the first cycle through the bypass
    drive(mk(1, 3, 9, 2'b01, 3, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    drive(mk(1, 3, 11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    idle();
    chk("byp_first_prd", bus_if.prdbadr, 3);
    chk("byp_first_pwr", {bus_if.pwrite, bus_if.pwrbadr[3:0]}, {2'b01, 4'd8});
    chk("byp_first_mw", {bus_if.m_write, bus_if.m_wrradr[9:0]}, {2'b01, 10'd11});
    @(posedge clk); #1;
    chk("byp_second_read", {bus_if.pread, bus_if.prdbadr}, {1'b1, 4'd8});
    chk("byp_second_quiet", {bus_if.pwrite, bus_if.m_write}, 0);

    // reset in the middle of traffic
    drive(vecs[6]);
    @(posedge clk); #1;
    drive(vecs[7]);
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_outputs", {bus_if.ready, bus_if.pread, bus_if.pwrite, bus_if.m_write, bus_if.m_read}, 0);
    chk("mid_rst_state", dbg_state, 0);
    idle();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    chk("reinit_row0", {bus_if.m_write, bus_if.m_wrradr[9:0]}, {2'b01, 10'd0});
    chk("reinit_din0", bus_if.m_din[BITMAPT-1:0], ident);
    chk("reinit_quiet", {bus_if.ready, bus_if.pread, bus_if.pwrite}, 0);
    @(posedge clk); #1;
    chk("reinit_row1", {bus_if.m_write, bus_if.m_wrradr[9:0]}, {2'b01, 10'd1});

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
